// File: rtl/lancer_de.sv
// Die-roll engine: shows an LFSR animation for ROLL_CYCLES, then reduces a sampled LFSR word into [min_de, max_de].
// Optional macro CRITIQUE_EN enables the critique/echec flags (tied to 0 otherwise).
module lancer_de #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ROLL_CYCLES = 25000000,
  parameter int unsigned ANIM_DIV    = 2500000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lancer,
  input  logic [6:0] min_de,
  input  logic [6:0] max_de,
  output logic [6:0] resultat,
  output logic       valide,
  output logic       en_cours,
  output logic       erreur,
  output logic       critique,
  output logic       echec
);

  typedef enum logic [1:0] {ATTENTE, ROULE, DIVISE, PRET} state_t;

  state_t           state, state_next;
  logic [15:0]      lfsr;
  logic             lancer_q;
  logic [6:0]       bmin, bmax;
  logic [CNT_W-1:0] roll_cnt, anim_cnt;
  logic [4:0]       step_cnt;
  logic [15:0]      dividend;
  logic [7:0]       rem;

  logic       depart, idle, roll_last, anim_hit, div_done, bounds_bad, in_range;
  logic [7:0] range;
  logic [8:0] rem_sh;
  logic [7:0] rem_next;
  logic [6:0] res_final;

  assign depart     = lancer & ~lancer_q;
  assign idle       = (state == ATTENTE) || (state == PRET);
  assign roll_last  = (roll_cnt == CNT_W'(ROLL_CYCLES - 1));
  assign anim_hit   = (anim_cnt == CNT_W'(ANIM_DIV - 1));
  assign div_done   = (step_cnt == 5'd16);
  assign bounds_bad = (bmin > bmax);
  assign in_range   = (lfsr[6:0] >= bmin) && (lfsr[6:0] <= bmax);

  // Restoring reduction: rem stays below range (<= 128), so the shifted value fits in 9 bits.
  assign range     = {1'b0, bmax} - {1'b0, bmin} + 8'd1;
  assign rem_sh    = {rem, dividend[15]};
  assign rem_next  = (rem_sh >= {1'b0, range}) ? 8'(rem_sh - {1'b0, range}) : rem_sh[7:0];
  assign res_final = bmin + rem[6:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ATTENTE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ATTENTE, PRET: if (depart) state_next = ROULE;
      ROULE:         if (roll_last) state_next = bounds_bad ? PRET : DIVISE;
      DIVISE:        if (div_done) state_next = PRET;
      default:       state_next = ATTENTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      lancer_q <= 1'b0;
      bmin     <= '0;
      bmax     <= '0;
      roll_cnt <= '0;
      anim_cnt <= '0;
      step_cnt <= '0;
      dividend <= '0;
      rem      <= '0;
      resultat <= '0;
      valide   <= 1'b0;
      en_cours <= 1'b0;
      erreur   <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      lancer_q <= lancer;
      case (state)
        ATTENTE, PRET: begin
          if (depart) begin
            bmin     <= min_de;
            bmax     <= max_de;
            valide   <= 1'b0;
            erreur   <= 1'b0;
            en_cours <= 1'b1;
            roll_cnt <= '0;
            anim_cnt <= '0;
            step_cnt <= '0;
          end
        end
        ROULE: begin
          roll_cnt <= roll_cnt + 1'b1;
          if (anim_hit) begin
            anim_cnt <= '0;
            if (in_range) resultat <= lfsr[6:0];
          end else begin
            anim_cnt <= anim_cnt + 1'b1;
          end
          if (roll_last) begin
            roll_cnt <= '0;
            dividend <= lfsr;
            rem      <= '0;
            step_cnt <= '0;
            // Inverted bounds finish here; overrides any animation update above.
            if (bounds_bad) begin
              resultat <= bmin;
              valide   <= 1'b1;
              erreur   <= 1'b1;
              en_cours <= 1'b0;
            end
          end
        end
        DIVISE: begin
          if (!div_done) begin
            rem      <= rem_next;
            dividend <= {dividend[14:0], 1'b0};
            step_cnt <= step_cnt + 1'b1;
          end else begin
            resultat <= res_final;
            valide   <= 1'b1;
            en_cours <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CRITIQUE_EN
  always_ff @(posedge clk) begin
    if (rst || (idle && depart)) begin
      critique <= 1'b0;
      echec    <= 1'b0;
    end else if (state == DIVISE && div_done) begin
      critique <= (res_final == bmax);
      echec    <= (res_final == bmin);
    end
  end
`else
  assign critique = 1'b0;
  assign echec    = 1'b0;
`endif

endmodule
